instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 16'h0001, SHALL be the PC increment per fetched instruction (word-addressed).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL request the instruction word at imem_addr.
REQ-006 imem_addr  output  16  SHALL carry the fetch address.
REQ-007 imem_ack  input  1  SHALL indicate that imem_rdata is valid in this cycle.
REQ-008 imem_rdata  input  16  SHALL carry the instruction word returned by memory.
REQ-009 stall  input  1  SHALL be asserted by the downstream register-file/decode stage to hold the current instruction.
REQ-010 redirect  input  1  SHALL request a PC change (branch/jump/writeback-driven).
REQ-011 redirect_pc  input  16  SHALL carry the target address, sampled when redirect=1.
REQ-012 instruc_out  output  16  SHALL carry the latched instruction and SHALL drive the register file's instruc_in.
REQ-013 pc_out  output  16  SHALL carry the address of instruc_out.
REQ-014 valid_out  output  1  SHALL be high when instruc_out holds a live instruction.
REQ-015 fetch_err  output  1  SHALL be a sticky fetch-timeout flag.

Function
REQ-016 All outputs SHALL be registered, except imem_addr, which SHALL equal the PC register combinationally.
REQ-017 The FSM SHALL have two states: S_REQ (imem_req=1) and S_VALID (imem_req=0, valid_out=1).
REQ-018 In S_REQ, on imem_ack=1, the next edge SHALL latch instruc_out<=imem_rdata, pc_out<=PC, PC<=PC+PC_STEP, and enter S_VALID.
REQ-019 In S_REQ without ack, the block SHALL hold imem_req=1 and keep the address stable.
REQ-020 In S_VALID with stall=1, instruc_out, pc_out and valid_out SHALL hold; with stall=0, the next state SHALL be S_REQ and valid_out SHALL drop to 0.
REQ-021 Throughput SHALL be at most one instruction per two cycles; ack-to-valid_out latency SHALL be one cycle.
REQ-022 redirect=1 SHALL take priority over stall and ack in any state: next edge PC<=redirect_pc, valid_out<=0, state S_REQ; imem_rdata acked in the same cycle SHALL be discarded.
REQ-023 PC addition SHALL be 16-bit modulo: 16'hFFFF+1 SHALL wrap to 16'h0000 without a flag.
REQ-024 instruc_out SHALL be 16'h0000 whenever valid_out=0 after reset or redirect.

Reset
REQ-025 While reset=1: PC<=RESET_PC, state<=S_REQ, imem_req<=0, valid_out<=0, instruc_out<=0, pc_out<=0, fetch_err<=0; reset SHALL override redirect, stall and ack.
REQ-026 imem_req SHALL assert on the first edge after reset deasserts; reset mid-fetch SHALL abandon the outstanding request.

Configuration
REQ-027 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL count S_REQ cycles without ack; at 15, fetch_err SHALL set (sticky until reset), imem_req SHALL drop for one cycle, then reissue at the same PC, and the counter SHALL clear.
REQ-028 Macro undefined: no counter SHALL exist and fetch_err SHALL be tied to 0.

Structure
REQ-029 State encodings, the NOP constant 16'h0000, and the timeout limit 4'd15 SHALL live in the shared include fetch_defs.v.
REQ-030 The timeout counter SHALL be a sub-module, fetch_wdog, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-031 Reset 2 cycles, then ack on the first request with rdata=16'hF120 -> imem_addr=16'h0000; next cycle valid_out=1, instruc_out=16'hF120, pc_out=16'h0000; PC=16'h0001.
REQ-032 Hold stall=1 for 3 cycles while valid -> instruc_out and valid_out stable and imem_req=0; release stall -> valid_out=0 and imem_req=1 at addr 16'h0001.
REQ-033 Assert redirect with redirect_pc=16'h0040 in the same cycle as ack -> acked data discarded, valid_out=0, next imem_addr=16'h0040.
REQ-034 RESET_PC=16'hFFFF with one ack -> pc_out=16'hFFFF and the next imem_addr=16'h0000.
REQ-035 FETCH_TIMEOUT_EN defined, ack withheld 15 cycles -> fetch_err=1 and a one-cycle imem_req gap; fetch_err stays high until reset. Macro undefined -> fetch_err stays 0.
REQ-036 Assert reset while in S_REQ awaiting ack -> next cycle imem_req=0, valid_out=0, PC=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, NOP word and
// the fetch-timeout limit used when FETCH_TIMEOUT_EN is defined.
package instr_fetch_pkg;

    typedef enum logic {
        S_REQ   = 1'b0,
        S_VALID = 1'b1
    } fetch_state_e;

    localparam logic [15:0] NOP           = 16'h0000;
    localparam logic [3:0]  TIMEOUT_LIMIT = 4'd15;

endpackage

// File: rtl/fetch_wdog.sv
// Fetch watchdog: counts consecutive unacknowledged request cycles and pulses
// expired on the cycle that would bring the count to TIMEOUT_LIMIT.
module fetch_wdog (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    output logic expired
);
    import instr_fetch_pkg::*;

    logic [3:0] cnt_q;

    assign expired = active && (cnt_q == TIMEOUT_LIMIT - 4'd1);

    always_ff @(posedge clk) begin
        if (reset || clear || !active || expired) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests words from instruction memory and hands one
// latched instruction at a time to decode. FETCH_TIMEOUT_EN adds a sticky timeout flag.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instruc_out,
    output logic [15:0] pc_out,
    output logic        valid_out,
    output logic        fetch_err
);
    import instr_fetch_pkg::*;

    fetch_state_e state_q;
    logic [15:0]  pc_q;
    logic [15:0]  instr_q;
    logic [15:0]  pc_out_q;
    logic         req_q;
    logic         valid_q;
    logic         accept;
    logic         timeout;

    // Ack only counts while a request is actually on the bus.
    assign accept = (state_q == S_REQ) && req_q && imem_ack;

`ifdef FETCH_TIMEOUT_EN
    logic wait_cycle;
    logic err_q;

    assign wait_cycle = (state_q == S_REQ) && req_q && !imem_ack;

    fetch_wdog u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (redirect),
        .active  (wait_cycle),
        .expired (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (timeout && !redirect) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= NOP;
            pc_out_q <= 16'h0000;
        end else if (redirect) begin
            state_q <= S_REQ;
            pc_q    <= redirect_pc;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            instr_q <= NOP;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (accept) begin
                        state_q  <= S_VALID;
                        instr_q  <= imem_rdata;
                        pc_out_q <= pc_q;
                        pc_q     <= pc_q + PC_STEP;
                        req_q    <= 1'b0;
                        valid_q  <= 1'b1;
                    end else begin
                        // A timeout leaves a one-cycle gap before reissuing at the same PC.
                        req_q <= !timeout;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        instr_q <= NOP;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign valid_out   = valid_q;
    assign instruc_out = instr_q;
    assign pc_out      = pc_out_q;

endmodule
